// File: rtl/spi_flash_pp_ctrl.sv
// W25Q16 page-program command sequencer that feeds an SPI frame shifter: WREN, CS gap, PP + addr + data, tPP wait.
// Define PP_ERASE_EN to prepend an optional WREN + sector-erase (20h) sequence when i_pp_erase is set.
module spi_flash_pp_ctrl #(
    parameter int unsigned WAIT_CS_CYCLES = 4,
    parameter int unsigned T_PP_CYCLES    = 150000,
    parameter int unsigned T_SE_CYCLES    = 20000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_pp_start,
    input  logic [23:0] i_pp_addr,
    input  logic [8:0]  i_pp_len,
    input  logic        i_pp_erase,
    input  logic [7:0]  i_wr_data,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    output logic        o_spi_start,
    output logic [23:0] o_spi_wrdata,
    output logic [7:0]  o_spi_width,
    output logic        o_spi_cs_keep,
    input  logic        i_spi_done,
    output logic        o_pp_busy,
    output logic        o_pp_done,
    output logic        o_pp_err
);

    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(WAIT_CS_CYCLES - 1);
    localparam logic [CNT_W-1:0] PP_LAST  = CNT_W'(T_PP_CYCLES - 1);

    typedef enum logic [4:0] {
        S_IDLE, S_WREN, S_WREN_W, S_GAP, S_CMD, S_CMD_W, S_ADDR, S_ADDR_W,
        S_DREQ, S_DATA, S_DATA_W, S_PROG, S_DONE
`ifdef PP_ERASE_EN
        , S_SE, S_SE_W, S_SEA, S_SEA_W, S_SE_WAIT
`endif
    } state_t;

    state_t           r_state;
    logic [23:0]      r_addr;
    logic [8:0]       r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic [9:0]       w_page_end;
    logic             w_req_bad;
    logic             w_take;

`ifdef PP_ERASE_EN
    localparam logic [CNT_W-1:0] SE_LAST = CNT_W'(T_SE_CYCLES - 1);
    logic r_erase_pend;
    logic r_after_erase;
`else
    logic w_unused;
    assign w_unused = i_pp_erase ^ (T_SE_CYCLES == 32'd0);
`endif

    // A request must not run past the end of its 256-byte page.
    assign w_page_end = 10'(i_pp_addr[7:0]) + 10'(i_pp_len);
    assign w_req_bad  = (i_pp_len == 9'd0) || (w_page_end > 10'd256);

    // Byte handshake with the source FIFO happens only while parked in DREQ.
    assign w_take     = (r_state == S_DREQ) && i_wr_valid;
    assign o_wr_ready = w_take;

    // Enter a frame state and present its payload; payload holds until the next launch.
    task automatic launch(input state_t nxt, input logic [23:0] data,
                          input logic [7:0] width, input logic keep);
        r_state       <= nxt;
        o_spi_start   <= 1'b1;
        o_spi_wrdata  <= data;
        o_spi_width   <= width;
        o_spi_cs_keep <= keep;
    endtask

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_addr        <= 24'd0;
            r_rem         <= 9'd0;
            r_cnt         <= '0;
            o_spi_start   <= 1'b0;
            o_spi_wrdata  <= 24'd0;
            o_spi_width   <= 8'd0;
            o_spi_cs_keep <= 1'b0;
            o_pp_busy     <= 1'b0;
            o_pp_done     <= 1'b0;
            o_pp_err      <= 1'b0;
`ifdef PP_ERASE_EN
            r_erase_pend  <= 1'b0;
            r_after_erase <= 1'b0;
`endif
        end else begin
            o_spi_start <= 1'b0;
            o_pp_done   <= 1'b0;
            o_pp_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_pp_start) begin
                        if (w_req_bad) begin
                            o_pp_err <= 1'b1;
                        end else begin
                            r_addr    <= i_pp_addr;
                            r_rem     <= i_pp_len;
                            o_pp_busy <= 1'b1;
`ifdef PP_ERASE_EN
                            r_erase_pend  <= i_pp_erase;
                            r_after_erase <= 1'b0;
`endif
                            launch(S_WREN, 24'h000006, 8'd8, 1'b0);
                        end
                    end
                end
                S_WREN:   r_state <= S_WREN_W;
                S_WREN_W: begin
                    if (i_spi_done) begin
                        r_state <= S_GAP;
                        r_cnt   <= '0;
                    end
                end
                // CS-high gap after every keep=0 frame; destination depends on erase progress.
                S_GAP: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == GAP_LAST) begin
`ifdef PP_ERASE_EN
                        if (r_erase_pend) begin
                            launch(S_SE, 24'h000020, 8'd8, 1'b1);
                        end else if (r_after_erase) begin
                            r_after_erase <= 1'b0;
                            launch(S_WREN, 24'h000006, 8'd8, 1'b0);
                        end else begin
                            launch(S_CMD, 24'h000002, 8'd8, 1'b1);
                        end
`else
                        launch(S_CMD, 24'h000002, 8'd8, 1'b1);
`endif
                    end
                end
                S_CMD:   r_state <= S_CMD_W;
                S_CMD_W: begin
                    if (i_spi_done) launch(S_ADDR, r_addr, 8'd24, 1'b1);
                end
                S_ADDR:   r_state <= S_ADDR_W;
                S_ADDR_W: begin
                    if (i_spi_done) r_state <= S_DREQ;
                end
                S_DREQ: begin
                    if (w_take) launch(S_DATA, {16'h0000, i_wr_data}, 8'd8, r_rem > 9'd1);
                end
                S_DATA:   r_state <= S_DATA_W;
                S_DATA_W: begin
                    if (i_spi_done) begin
                        r_rem <= r_rem - 9'd1;
                        if (r_rem == 9'd1) begin
                            r_state <= S_PROG;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= S_DREQ;
                        end
                    end
                end
                S_PROG: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == PP_LAST) begin
                        r_state   <= S_DONE;
                        o_pp_done <= 1'b1;
                        o_pp_busy <= 1'b0;
                    end
                end
                S_DONE: r_state <= S_IDLE;
`ifdef PP_ERASE_EN
                S_SE:   r_state <= S_SE_W;
                S_SE_W: begin
                    if (i_spi_done) launch(S_SEA, {r_addr[23:12], 12'h000}, 8'd24, 1'b0);
                end
                S_SEA:   r_state <= S_SEA_W;
                S_SEA_W: begin
                    if (i_spi_done) begin
                        r_state <= S_SE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                S_SE_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == SE_LAST) begin
                        r_state       <= S_GAP;
                        r_cnt         <= '0;
                        r_erase_pend  <= 1'b0;
                        r_after_erase <= 1'b1;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_pp_ctrl.sv
// Scoreboard bench for spi_flash_pp_ctrl: expected frames queued per request, checked as the shifter model sees them.
module tb_spi_flash_pp_ctrl;

    localparam int unsigned WAIT_CS = 4;
    localparam int unsigned T_PP    = 40;
    localparam int unsigned T_SE    = 30;
    localparam int unsigned SH_LAT  = 10;
`ifdef PP_ERASE_EN
    localparam bit ERASE_BUILD = 1'b1;
`else
    localparam bit ERASE_BUILD = 1'b0;
`endif

    typedef struct packed {
        logic [23:0] data;
        logic [7:0]  width;
        logic        keep;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_pp_start = 1'b0;
    logic [23:0] i_pp_addr = 24'd0;
    logic [8:0]  i_pp_len = 9'd0;
    logic        i_pp_erase = 1'b0;
    logic [7:0]  i_wr_data;
    logic        i_wr_valid;
    logic        o_wr_ready;
    logic        o_spi_start;
    logic [23:0] o_spi_wrdata;
    logic [7:0]  o_spi_width;
    logic        o_spi_cs_keep;
    logic        i_spi_done;
    logic        o_pp_busy;
    logic        o_pp_done;
    logic        o_pp_err;

    logic done_m = 1'b0;
    logic spur   = 1'b0;
    assign i_spi_done = done_m | spur;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    frame_t     exp_q[$];
    logic [7:0] src_q[$];
    int         start_cq[$];
    int         done_cq[$];
    int tot_starts = 0, pd_cnt = 0, pd_cyc = 0, ready_cnt = 0;
    int byte_idx = 0, hold_idx = -1, hold_left = 0;

    spi_flash_pp_ctrl #(
        .WAIT_CS_CYCLES(WAIT_CS),
        .T_PP_CYCLES   (T_PP),
        .T_SE_CYCLES   (T_SE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_pp_start   (i_pp_start),
        .i_pp_addr    (i_pp_addr),
        .i_pp_len     (i_pp_len),
        .i_pp_erase   (i_pp_erase),
        .i_wr_data    (i_wr_data),
        .i_wr_valid   (i_wr_valid),
        .o_wr_ready   (o_wr_ready),
        .o_spi_start  (o_spi_start),
        .o_spi_wrdata (o_spi_wrdata),
        .o_spi_width  (o_spi_width),
        .o_spi_cs_keep(o_spi_cs_keep),
        .i_spi_done   (i_spi_done),
        .o_pp_busy    (o_pp_busy),
        .o_pp_done    (o_pp_done),
        .o_pp_err     (o_pp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_frame(input logic [23:0] d, input logic [7:0] w, input logic k);
        frame_t f;
        f.data  = d;
        f.width = w;
        f.keep  = k;
        exp_q.push_back(f);
    endfunction

    // Source FIFO model: bytes are presented in order; a byte is popped the negedge after its handshake.
    bit pend = 1'b0;
    initial begin
        i_wr_valid = 1'b0;
        i_wr_data  = 8'd0;
        forever begin
            @(negedge clk);
            if (pend && src_q.size() > 0) begin
                void'(src_q.pop_front());
                byte_idx++;
            end
            pend = 1'b0;
            if (byte_idx == hold_idx && hold_left > 0) begin
                hold_left--;
                i_wr_valid = 1'b0;
            end else if (src_q.size() > 0) begin
                i_wr_valid = 1'b1;
                i_wr_data  = src_q[0];
            end else begin
                i_wr_valid = 1'b0;
            end
            #1;
            if (i_wr_valid && o_wr_ready) begin
                pend = 1'b1;
                ready_cnt++;
            end
        end
    end

    // Shifter model and frame monitor: done SH_LAT cycles after each start.
    frame_t cur;
    frame_t e;
    bit     sh_busy = 1'b0;
    int     sh_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            sh_busy = 1'b0;
            sh_cnt  = 0;
            done_m  = 1'b0;
        end else begin
            done_m = 1'b0;
            if (sh_busy) begin
                sh_cnt++;
                if (sh_cnt == SH_LAT) begin
                    done_m  = 1'b1;
                    sh_busy = 1'b0;
                    done_cq.push_back(cyc);
                    check("hold_data", 32'(o_spi_wrdata), 32'(cur.data));
                    check("hold_width", 32'(o_spi_width), 32'(cur.width));
                    check("hold_keep", 32'(o_spi_cs_keep), 32'(cur.keep));
                end
            end
            if (o_spi_start === 1'b1) begin
                tot_starts++;
                start_cq.push_back(cyc);
                check("start_while_busy", 32'(sh_busy), 32'd0);
                check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("frame%0d_data", tot_starts), 32'(o_spi_wrdata), 32'(e.data));
                    check($sformatf("frame%0d_width", tot_starts), 32'(o_spi_width), 32'(e.width));
                    check($sformatf("frame%0d_keep", tot_starts), 32'(o_spi_cs_keep), 32'(e.keep));
                end
                cur.data  = o_spi_wrdata;
                cur.width = o_spi_width;
                cur.keep  = o_spi_cs_keep;
                sh_busy   = 1'b1;
                sh_cnt    = 0;
            end
            if (o_pp_done === 1'b1) begin
                pd_cnt++;
                pd_cyc = cyc;
                check("busy_low_at_done", 32'(o_pp_busy), 32'd0);
            end
        end
    end

    int t0, pd0, r0;
    bit er_on;

    // Queue expectations, then pulse pp_start and check start latency.
    task automatic run_req(input logic [23:0] addr, input int len, input logic erase,
                           input int h_idx, input int h_len);
        er_on = erase && ERASE_BUILD;
        if (er_on) begin
            push_frame(24'h000006, 8'd8, 1'b0);
            push_frame(24'h000020, 8'd8, 1'b1);
            push_frame({addr[23:12], 12'h000}, 8'd24, 1'b0);
        end
        push_frame(24'h000006, 8'd8, 1'b0);
        push_frame(24'h000002, 8'd8, 1'b1);
        push_frame(addr, 8'd24, 1'b1);
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            b = 8'hA1 + 8'(i * 17);
            src_q.push_back(b);
            push_frame({16'h0000, b}, 8'd8, i < len - 1);
        end
        start_cq.delete();
        done_cq.delete();
        byte_idx  = 0;
        hold_idx  = h_idx;
        hold_left = h_len;
        @(negedge clk);
        i_pp_addr  = addr;
        i_pp_len   = 9'(len);
        i_pp_erase = erase;
        i_pp_start = 1'b1;
        t0  = cyc;
        pd0 = pd_cnt;
        r0  = ready_cnt;
        @(negedge clk);
        i_pp_start = 1'b0;
        #1;
        check("start_latency", 32'(o_spi_start), 32'd1);
        check("busy_set", 32'(o_pp_busy), 32'd1);
        check("start_cycle", 32'(cyc - t0), 32'd1);
    endtask

    task automatic finish_req(input int len);
        int k;
        k = 0;
        while (pd_cnt == pd0 && k < len * 40 + int'(T_PP + T_SE) + 400) begin
            @(negedge clk);
            k++;
        end
        #2;
        check("pp_done_seen", 32'(pd_cnt - pd0), 32'd1);
        check("frames_left", 32'(exp_q.size()), 32'd0);
        check("ready_pulses", 32'(ready_cnt - r0), 32'(len));
        if (done_cq.size() > 0)
            check("done_latency", 32'(pd_cyc - done_cq[done_cq.size() - 1]), 32'(T_PP + 1));
        else
            check("done_frames", 32'(done_cq.size()), 32'd1);
        if (er_on && start_cq.size() > 3)
            check("se_wait_gap", 32'(start_cq[3] - done_cq[2]), 32'(T_SE + WAIT_CS + 1));
        else if (!er_on && start_cq.size() > 1)
            check("cs_gap", 32'(start_cq[1] - done_cq[0]), 32'(WAIT_CS + 1));
        else
            check("frame_count", 32'(start_cq.size() > 1), 32'd1);
        exp_q.delete();
        src_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic reject(input logic [23:0] addr, input logic [8:0] len, input string tag);
        int s0;
        s0 = tot_starts;
        @(negedge clk);
        i_pp_addr  = addr;
        i_pp_len   = len;
        i_pp_start = 1'b1;
        @(negedge clk);
        i_pp_start = 1'b0;
        #1;
        check({tag, "_err"}, 32'(o_pp_err), 32'd1);
        check({tag, "_busy"}, 32'(o_pp_busy), 32'd0);
        @(negedge clk);
        #1;
        check({tag, "_err_pulse"}, 32'(o_pp_err), 32'd0);
        repeat (5) @(negedge clk);
        check({tag, "_no_frame"}, 32'(tot_starts - s0), 32'd0);
    endtask

    initial begin
        int k;
        #1;
        check("rst_spi_start", 32'(o_spi_start), 32'd0);
        check("rst_wrdata", 32'(o_spi_wrdata), 32'd0);
        check("rst_width", 32'(o_spi_width), 32'd0);
        check("rst_keep", 32'(o_spi_cs_keep), 32'd0);
        check("rst_busy", 32'(o_pp_busy), 32'd0);
        check("rst_done_err", 32'({o_pp_done, o_pp_err, o_wr_ready}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic 4-byte program.
        run_req(24'h000100, 4, 1'b0, -1, 0);
        finish_req(4);

        // Page crossing and zero length are rejected; an exactly full page is accepted.
        reject(24'h0000F0, 9'd17, "rej_cross");
        reject(24'h000100, 9'd0, "rej_zero");
        run_req(24'h000000, 256, 1'b0, -1, 0);
        finish_req(256);

        // Source underflow before byte 2: stall in DREQ with CS held.
        run_req(24'h000100, 4, 1'b0, 1, 50);
        k = 0;
        while (hold_left != 1 && k < 400) begin @(negedge clk); #2; k++; end
        check("stall_reached", 32'(hold_left), 32'd1);
        check("stall_frames", 32'(start_cq.size()), 32'd4);
        check("stall_keep", 32'(o_spi_cs_keep), 32'd1);
        check("stall_ready", 32'(o_wr_ready), 32'd0);
        check("stall_busy", 32'(o_pp_busy), 32'd1);
        finish_req(4);

        // Spurious done during GAP and pp_start during ADDR_W are ignored.
        run_req(24'h000100, 4, 1'b0, -1, 0);
        k = 0;
        while (done_cq.size() < 1 && k < 100) begin @(negedge clk); #2; k++; end
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        k = 0;
        while (start_cq.size() < 3 && k < 100) begin @(negedge clk); #2; k++; end
        @(negedge clk);
        i_pp_start = 1'b1;
        @(negedge clk);
        i_pp_start = 1'b0;
        finish_req(4);

        // Erase request (honoured only in the erase build).
        run_req(24'h012345, 3, 1'b1, -1, 0);
        finish_req(3);
        i_pp_erase = 1'b0;

        // Asynchronous reset during DATA_W of byte 2, then a full rerun.
        run_req(24'h000100, 4, 1'b0, -1, 0);
        k = 0;
        while (start_cq.size() < 5 && k < 200) begin @(negedge clk); #2; k++; end
        check("reached_byte2", 32'(start_cq.size()), 32'd5);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_outputs", 32'({o_spi_start, o_spi_cs_keep, o_pp_busy, o_pp_done, o_pp_err, o_wr_ready}), 32'd0);
        check("arst_payload", 32'(o_spi_wrdata), 32'd0);
        check("arst_width", 32'(o_spi_width), 32'd0);
        exp_q.delete();
        src_q.delete();
        pd0 = pd_cnt;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (T_PP + 20) @(negedge clk);
        check("no_done_after_reset", 32'(pd_cnt - pd0), 32'd0);
        run_req(24'h000100, 4, 1'b0, -1, 0);
        finish_req(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
